// File: rtl/mem_req_arb.sv
// Single-outstanding arbiter between instruction fetch and load/store onto one 64-bit sram port.
// Handles byte-lane write masks, store data lane shifting and load field extraction with sign extension.
module mem_req_arb #(
  parameter int ADDR_W = 64,
  parameter bit RR_EN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [31:0]       if_resp_data,
  output logic              if_resp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_wr,
  input  logic [1:0]        ls_req_size,
  input  logic              ls_req_signed,
  input  logic [63:0]       ls_req_wdata,
  output logic              ls_resp_valid,
  input  logic              ls_resp_ready,
  output logic [63:0]       ls_resp_rdata,
  output logic              ls_resp_err,
  output logic              mem_en,
  output logic [7:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [2:0] off, input logic [1:0] size);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << size)) - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] rd, input logic [2:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [63:0] f;
    f = rd >> {off, 3'b000};
    case (size)
      2'd0:    return {{56{sgn & f[7]}}, f[7:0]};
      2'd1:    return {{48{sgn & f[15]}}, f[15:0]};
      2'd2:    return {{32{sgn & f[31]}}, f[31:0]};
      default: return f;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              port_ls_q, port_ls_d;
  logic              last_ls_q, last_ls_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q, sgn_q, mis_q;
  logic [63:0]       wdata_q, rdata_q;
  logic              gnt_ls, gnt_if, accept, issue_go;

  // On a tie, round-robin favours the port that did not win last time.
  assign gnt_ls = ls_req_valid && (!if_req_valid || !RR_EN || !last_ls_q);
  assign gnt_if = if_req_valid && !gnt_ls;
  assign accept = (state_q == IDLE) && (gnt_ls || gnt_if);

  assign if_req_ready = (state_q == IDLE) && gnt_if;
  assign ls_req_ready = (state_q == IDLE) && gnt_ls;

  always_comb begin
    state_d   = state_q;
    port_ls_d = port_ls_q;
    last_ls_d = last_ls_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = ISSUE;
        port_ls_d = gnt_ls;
        last_ls_d = gnt_ls;
      end
      ISSUE:   state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (port_ls_q ? ls_resp_ready : if_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      port_ls_q <= 1'b0;
      last_ls_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_ls_q <= port_ls_d;
      last_ls_q <= last_ls_d;
    end
  end

  // Request latch at acceptance; fetches are treated as unsigned 32-bit loads.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (gnt_ls) begin
        addr_q  <= ls_req_addr;
        size_q  <= ls_req_size;
        wr_q    <= ls_req_wr;
        sgn_q   <= ls_req_signed;
        wdata_q <= ls_req_wdata;
        mis_q   <= misaligned(ls_req_addr[2:0], ls_req_size);
      end else begin
        addr_q  <= if_req_addr;
        size_q  <= 2'd2;
        wr_q    <= 1'b0;
        sgn_q   <= 1'b0;
        wdata_q <= '0;
        mis_q   <= |if_req_addr[1:0];
      end
    end
    // Capture stage: sram rdata is valid the cycle after mem_en.
    if (state_q == CAPT) begin
      rdata_q <= (wr_q || mis_q) ? '0 : extract(mem_rdata, addr_q[2:0], size_q, sgn_q);
    end
  end

  assign issue_go  = (state_q == ISSUE) && !mis_q;
  assign mem_en    = issue_go;
  assign mem_we    = (issue_go && wr_q) ? byte_mask(addr_q[2:0], size_q) : 8'h00;
  assign mem_addr  = (state_q == ISSUE) ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wdata = (issue_go && wr_q) ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'h0;

  assign if_resp_valid = (state_q == RESP) && !port_ls_q;
  assign ls_resp_valid = (state_q == RESP) && port_ls_q;
  assign if_resp_data  = if_resp_valid ? rdata_q[31:0] : 32'h0;
  assign if_resp_err   = if_resp_valid && mis_q;
  assign ls_resp_rdata = ls_resp_valid ? rdata_q : 64'h0;
  assign ls_resp_err   = ls_resp_valid && mis_q;

endmodule
